// File: rtl/miinst_issue_queue_if.sv
// Shared micro-instruction types plus the fetch-side bundle and issue-side uop interfaces
// used by miinst_issue_queue.
`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_pkg;
    typedef enum logic [3:0] {
        MIOP_NOP   = 4'd0,
        MIOP_SLLI  = 4'd1,
        MIOP_LOAD  = 4'd2,
        MIOP_STORE = 4'd3,
        MIOP_ADD   = 4'd4,
        MIOP_BR    = 4'd5
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } miinst_t;

    typedef logic [31:0] addr_t;
endpackage

// valid/ready on both interfaces: a transfer happens on a rising clk edge where valid && ready
// are both high; the producer may not assume acceptance before that edge.
interface miq_bundle_if #(parameter int N_SLOT = `MQ_N);
    import miinst_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    miinst_t [N_SLOT-1:0] in_miinst;
    addr_t                in_pc;

    modport master (output in_valid, output in_miinst, output in_pc, input in_ready);
    modport slave  (input in_valid, input in_miinst, input in_pc, output in_ready);
endinterface

interface miq_uop_if;
    import miinst_pkg::*;
    logic    out_valid;
    logic    out_ready;
    miinst_t out_miinst;
    addr_t   out_pc;
    logic    out_last;

    modport master (output out_valid, output out_miinst, output out_pc, output out_last, input out_ready);
    modport slave  (input out_valid, input out_miinst, input out_pc, input out_last, output out_ready);
endinterface

// File: rtl/miinst_issue_queue.sv
// Buffers whole micro-instruction bundles and issues their non-NOP slots one per cycle.
// Optional MIQ_PERF_EN adds a saturating fetch-stall counter output perf_stall_cnt.
`ifndef MQ_N
`define MQ_N 4
`endif

module miinst_issue_queue
    import miinst_pkg::*;
#(
    parameter int N_SLOT = `MQ_N,
    parameter int DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    miq_bundle_if.slave fetch,
    miq_uop_if.master   issue
`ifdef MIQ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [N_SLOT-1:0]    mask_q [DEPTH];
    logic [N_SLOT-1:0]    mask_d [DEPTH];
    miinst_t [N_SLOT-1:0] slots_q [DEPTH];
    addr_t                pc_q [DEPTH];

    logic [N_SLOT-1:0] in_mask;
    logic [N_SLOT-1:0] head_mask;
    logic [SW-1:0]     sel;
    logic              in_ready, out_valid, out_last;
    logic              push, push_wr, hs, pop;

    always_comb begin
        in_mask = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            in_mask[i] = (fetch.in_miinst[i].op != MIOP_NOP);
        end
    end

    assign head_mask = mask_q[rd_ptr_q];

    // Descending scan so the lowest set bit wins.
    always_comb begin
        sel = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (head_mask[i]) sel = SW'(i);
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_last  = out_valid && (head_mask != '0) &&
                       ((head_mask & (head_mask - N_SLOT'(1))) == '0);

    assign push    = fetch.in_valid && in_ready && !flush;
    assign push_wr = push && (in_mask != '0);
    assign hs      = out_valid && issue.out_ready;
    assign pop     = hs && out_last;

    always_comb begin
        mask_d   = mask_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (hs) mask_d[rd_ptr_q][sel] = 1'b0;
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_wr) begin
            mask_d[wr_ptr_q] = in_mask;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (push_wr && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_wr && pop) begin
            count_d = count_q - CW'(1);
        end
        // A same-cycle issue handshake is still consumed; everything buffered is dropped.
        if (flush) begin
            for (int d = 0; d < DEPTH; d++) mask_d[d] = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int d = 0; d < DEPTH; d++) mask_q[d] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < DEPTH; d++) begin
                slots_q[d] <= '0;
                pc_q[d]    <= '0;
            end
        end else if (push_wr) begin
            slots_q[wr_ptr_q] <= fetch.in_miinst;
            pc_q[wr_ptr_q]    <= fetch.in_pc;
        end
    end

    assign fetch.in_ready   = in_ready;
    assign issue.out_valid  = out_valid;
    assign issue.out_last   = out_last;
    assign issue.out_miinst = out_valid ? slots_q[rd_ptr_q][sel] : '0;
    assign issue.out_pc     = out_valid ? pc_q[rd_ptr_q] : '0;

`ifdef MIQ_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (fetch.in_valid && !in_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Bench for miinst_issue_queue: directed scenarios against constants, then random traffic
// against a queue-of-uops model of the issue order.
`ifndef MQ_N
`define MQ_N 4
`endif

module tb_miinst_issue_queue;
  import miinst_pkg::*;

  localparam int N     = `MQ_N;
  localparam int DEPTH = 2;
  localparam int W     = 1 + $bits(addr_t) + $bits(miinst_t);

  typedef miinst_t [N-1:0] bundle_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic flush = 1'b0;

  miq_bundle_if #(.N_SLOT(N)) bif();
  miq_uop_if uif();
`ifdef MIQ_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  miinst_issue_queue #(.N_SLOT(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .fetch (bif),
    .issue (uif)
`ifdef MIQ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // reference model: flat list of pending uops {last, pc, miinst} plus uops left per bundle
  logic [W-1:0] exp_q[$];
  int           bund_rem[$];
  bit           last_acc;
  int           stall_exp;

  function automatic miinst_t mk(miop_e op);
    miinst_t m;
    m.op  = op;
    m.rd  = 5'($urandom);
    m.rs1 = 5'($urandom);
    m.rs2 = 5'($urandom);
    m.imm = 13'($urandom);
    return m;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = '0;
    if ($urandom_range(0, 9) == 0) return b;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 2) != 0) b[i] = mk(miop_e'($urandom_range(1, 5)));
    end
    return b;
  endfunction

  task automatic drive(input bit v, input bundle_t b, input addr_t pc, input bit ordy, input bit fl);
    bif.in_valid  = v;
    bif.in_miinst = b;
    bif.in_pc     = pc;
    uif.out_ready = ordy;
    flush         = fl;
  endtask

  // advance one clock edge, updating the model from the inputs presented this cycle
  task automatic tick();
    bit acc, take;
    int idx[$];
    acc  = bif.in_valid && (bund_rem.size() < DEPTH) && !flush;
    take = (exp_q.size() != 0) && uif.out_ready;
    if (bif.in_valid && (bund_rem.size() >= DEPTH) && !flush) stall_exp++;
    last_acc = acc;
    if (flush) begin
      exp_q.delete();
      bund_rem.delete();
    end else begin
      if (take) begin
        void'(exp_q.pop_front());
        bund_rem[0] = bund_rem[0] - 1;
        if (bund_rem[0] == 0) void'(bund_rem.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < N; i++) if (bif.in_miinst[i].op != MIOP_NOP) idx.push_back(i);
        for (int k = 0; k < idx.size(); k++)
          exp_q.push_back({1'(k == idx.size() - 1), bif.in_pc, bif.in_miinst[idx[k]]});
        if (idx.size() != 0) bund_rem.push_back(idx.size());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, '0, 0, 0);
    rstn = 1'b0;
    exp_q.delete();
    bund_rem.delete();
    stall_exp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, 0);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    bund_rem.delete();
    stall_exp = 0;
    #1;
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bif.in_ready); end
    total++; if (uif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", uif.out_valid); end
    total++; if (uif.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", uif.out_last); end
    total++; if (uif.out_miinst !== '0) begin bad++; $display("FAIL reset_out_miinst got=%h want=0", uif.out_miinst); end
    total++; if (uif.out_pc !== '0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", uif.out_pc); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    tick();
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", bif.in_ready); end
    total++; if (uif.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%0b want=0", uif.out_valid); end
  endtask

  task automatic test_single();
    bundle_t b;
    b = '0;
    b[0] = mk(MIOP_SLLI);
    b[1] = mk(MIOP_LOAD);
    drive(1, b, 32'h1000, 1, 0);
    tick();
    drive(0, '0, '0, 1, 0);
    total++; if (uif.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid0 got=%0b want=1", uif.out_valid); end
    total++; if (uif.out_miinst !== b[0]) begin bad++; $display("FAIL single_slli got=%h want=%h", uif.out_miinst, b[0]); end
    total++; if (uif.out_last !== 1'b0) begin bad++; $display("FAIL single_last0 got=%0b want=0", uif.out_last); end
    total++; if (uif.out_pc !== 32'h1000) begin bad++; $display("FAIL single_pc0 got=%h want=1000", uif.out_pc); end
    tick();
    total++; if (uif.out_miinst !== b[1]) begin bad++; $display("FAIL single_load got=%h want=%h", uif.out_miinst, b[1]); end
    total++; if (uif.out_last !== 1'b1) begin bad++; $display("FAIL single_last1 got=%0b want=1", uif.out_last); end
    total++; if (uif.out_pc !== 32'h1000) begin bad++; $display("FAIL single_pc1 got=%h want=1000", uif.out_pc); end
    tick();
    total++; if (uif.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b want=0", uif.out_valid); end
  endtask

  task automatic test_backpressure();
    bundle_t b1, b2, b3;
    addr_t   got[$];
    addr_t   want[6];
    bit      b3_acc;
    b1 = '0; b2 = '0; b3 = '0;
    b1[0] = mk(MIOP_ADD);  b1[1] = mk(MIOP_STORE);
    b2[2] = mk(MIOP_LOAD);
    b3[0] = mk(MIOP_SLLI); b3[1] = mk(MIOP_BR); b3[3] = mk(MIOP_ADD);
    want = '{32'h2000, 32'h2000, 32'h3000, 32'h4000, 32'h4000, 32'h4000};
    drive(1, b1, 32'h2000, 0, 0);
    tick();
    drive(1, b2, 32'h3000, 0, 0);
    tick();
    total++; if (bif.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%0b want=0", bif.in_ready); end
    drive(1, b3, 32'h4000, 0, 0);
    for (int c = 0; c < 3; c++) begin
      total++; if (uif.out_miinst !== b1[0]) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", c, uif.out_miinst, b1[0]); end
      tick();
      total++; if (last_acc) begin bad++; $display("FAIL bp_held cyc=%0d got=accepted want=held", c); end
    end
    uif.out_ready = 1'b1;
    b3_acc = 1'b0;
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      if (uif.out_valid && uif.out_ready) got.push_back(uif.out_pc);
      tick();
      if (last_acc) begin
        b3_acc = 1'b1;
        bif.in_valid = 1'b0;
      end
    end
    total++; if (!b3_acc) begin bad++; $display("FAIL bp_third_accept got=0 want=1"); end
    total++; if (got.size() != 6) begin bad++; $display("FAIL bp_issue_count got=%0d want=6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      total++; if (got[k] !== want[k]) begin bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", k, got[k], want[k]); end
    end
  endtask

  task automatic test_nop_bundle();
    bundle_t ba, bn, bb;
    addr_t   pcs[$];
    bit      lasts[$];
    ba = '0; bn = '0; bb = '0;
    ba[3] = mk(MIOP_LOAD);
    bb[1] = mk(MIOP_STORE);
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive(1, ba, 32'h5000, 1, 0);
        1: drive(1, bn, 32'h6000, 1, 0);
        2: drive(1, bb, 32'h7000, 1, 0);
        default: drive(0, '0, '0, 1, 0);
      endcase
      if (uif.out_valid && uif.out_ready) begin
        pcs.push_back(uif.out_pc);
        lasts.push_back(uif.out_last);
      end
      tick();
    end
    total++; if (pcs.size() != 2) begin bad++; $display("FAIL nop_issue_count got=%0d want=2", pcs.size()); end
    if (pcs.size() == 2) begin
      total++; if (pcs[0] !== 32'h5000 || pcs[1] !== 32'h7000) begin bad++; $display("FAIL nop_order got=%h,%h want=5000,7000", pcs[0], pcs[1]); end
      total++; if (lasts[0] !== 1'b1 || lasts[1] !== 1'b1) begin bad++; $display("FAIL nop_last got=%0b,%0b want=1,1", lasts[0], lasts[1]); end
    end
  endtask

  task automatic test_flush();
    bundle_t ba, bb;
    int      seen;
    ba = '0; bb = '0;
    ba[0] = mk(MIOP_ADD);
    bb[0] = mk(MIOP_BR); bb[2] = mk(MIOP_SLLI);
    drive(1, ba, 32'h8000, 0, 0);
    tick();
    drive(1, bb, 32'h9000, 0, 1);
    tick();
    drive(0, '0, '0, 1, 0);
    total++; if (uif.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", uif.out_valid); end
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", bif.in_ready); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (uif.out_valid) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_issue got=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid();
    bundle_t ba;
    ba = '0;
    ba[1] = mk(MIOP_LOAD);
    drive(1, ba, 32'hA000, 0, 0);
    tick();
    drive(1, ba, 32'hA100, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    rstn = 1'b0;
    exp_q.delete();
    bund_rem.delete();
    stall_exp = 0;
    #1;
    total++; if (uif.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b want=0", uif.out_valid); end
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%0b want=1", bif.in_ready); end
    total++; if (uif.out_pc !== '0) begin bad++; $display("FAIL midrst_out_pc got=%h want=0", uif.out_pc); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

`ifdef MIQ_PERF_EN
  task automatic test_perf();
    bundle_t ba;
    ba = '0;
    ba[0] = mk(MIOP_ADD);
    do_reset();
    drive(1, ba, 32'hB000, 0, 0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) tick();
    drive(0, '0, '0, 0, 0);
    total++; if (perf_stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_count got=%0d want=5", perf_stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (perf_stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_after_flush got=%0d want=5", perf_stall_cnt); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 2) != 0, rand_bundle(), addr_t'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      total++;
      if (uif.out_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_out_valid cyc=%0d got=%0b want=%0b", c, uif.out_valid, exp_q.size() != 0);
      end
      total++;
      if (bif.in_ready !== (bund_rem.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", c, bif.in_ready, bund_rem.size() < DEPTH);
      end
      total++;
      if (exp_q.size() != 0) begin
        if ({uif.out_last, uif.out_pc, uif.out_miinst} !== exp_q[0]) begin
          bad++; $display("FAIL rnd_uop cyc=%0d got=%h want=%h", c, {uif.out_last, uif.out_pc, uif.out_miinst}, exp_q[0]);
        end
      end else if ({uif.out_last, uif.out_pc, uif.out_miinst} !== '0) begin
        bad++; $display("FAIL rnd_idle_zero cyc=%0d got=%h want=0", c, {uif.out_last, uif.out_pc, uif.out_miinst});
      end
      tick();
    end
`ifdef MIQ_PERF_EN
    total++; if (perf_stall_cnt !== 32'(stall_exp)) begin bad++; $display("FAIL rnd_perf got=%0d want=%0d", perf_stall_cnt, stall_exp); end
`endif
  endtask

  initial begin
    drive(0, '0, '0, 0, 0);
    stall_exp = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_nop_bundle();
    test_flush();
    test_reset_mid();
`ifdef MIQ_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
